elevator_request_scheduler: RTL

Collective-control scheduler for the elevator floor datapath. Latches floor calls into a pending bitmap and issues one target floor at a time to the elevator state machine, using SCAN ordering: keep serving calls in the current direction, then reverse. Runs a door dwell timer at each served floor. Sits between the call inputs (ui_in) and the elevator_state_machine requested_floor input.

---
 rtl/elevator_request_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/elevator_request_scheduler.sv
// SCAN-ordered collective-control scheduler: latches floor calls, issues one target at a time, times door dwell.
// Optional build macro INTERCEPT_EN: retarget mid-travel to pending floors passed on the way.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS   = 10,
  parameter int FLOOR_W      = 4,
  parameter int DWELL_CYCLES = 10000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  car_idle,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  door_open,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SELECT, TRAVEL, DOOR} state_t;

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      target_q, target_d;
  logic                    dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NUM_FLOORS-1:0]   clr;
  logic [NUM_FLOORS-1:0]   cur_hot, tgt_hot, above_mask, below_mask;
  logic [NUM_FLOORS-1:0]   up_pend, dn_pend;
  logic                    arrive;

  // Per-floor decode; an out-of-range current_floor leaves every floor "below".
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_dec
      assign cur_hot[gi]    = (current_floor == FLOOR_W'(gi));
      assign tgt_hot[gi]    = (target_q == FLOOR_W'(gi));
      assign above_mask[gi] = (FLOOR_W'(gi) > current_floor);
      assign below_mask[gi] = (FLOOR_W'(gi) < current_floor);
    end
  endgenerate

`ifdef INTERCEPT_EN
  logic [NUM_FLOORS-1:0] between_mask, between_pend;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_between
      assign between_mask[gi] = dir_up_q ?
        ((FLOOR_W'(gi) > current_floor) && (FLOOR_W'(gi) < target_q)) :
        ((FLOOR_W'(gi) < current_floor) && (FLOOR_W'(gi) > target_q));
    end
  endgenerate
  assign between_pend = pending_q & between_mask;
`endif

  function automatic logic [FLOOR_W-1:0] lowest_set(input logic [NUM_FLOORS-1:0] m);
    lowest_set = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--)
      if (m[f]) lowest_set = FLOOR_W'(f);
  endfunction

  function automatic logic [FLOOR_W-1:0] highest_set(input logic [NUM_FLOORS-1:0] m);
    highest_set = '0;
    for (int f = 0; f < NUM_FLOORS; f++)
      if (m[f]) highest_set = FLOOR_W'(f);
  endfunction

  assign up_pend = pending_q & above_mask;
  assign dn_pend = pending_q & below_mask;
  assign arrive  = car_idle && (current_floor == target_q);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dir_up_d = dir_up_q;
    cnt_d    = cnt_q;
    clr      = '0;
    case (state_q)
      IDLE: begin
        target_d = current_floor;
        // Look at the incoming calls too so SELECT starts the same cycle pending becomes visible.
        if ((pending_q | call_req) != '0) state_d = SELECT;
      end
      SELECT: begin
        if (pending_q == '0) begin
          state_d  = IDLE;
          target_d = current_floor;
        end else begin
          state_d = TRAVEL;
          if ((pending_q & cur_hot) != '0)
            target_d = current_floor;
          else if (dir_up_q && (up_pend != '0))
            target_d = lowest_set(up_pend);
          else if (!dir_up_q && (dn_pend != '0))
            target_d = highest_set(dn_pend);
          else begin
            dir_up_d = !dir_up_q;
            target_d = dir_up_q ? highest_set(dn_pend) : lowest_set(up_pend);
          end
        end
      end
      TRAVEL: begin
        if (arrive) begin
          clr     = tgt_hot;
          cnt_d   = DWELL_RELOAD;
          state_d = DOOR;
        end
`ifdef INTERCEPT_EN
        else if (between_pend != '0) begin
          target_d = dir_up_q ? lowest_set(between_pend) : highest_set(between_pend);
        end
`endif
      end
      DOOR: begin
        // Calls at the open floor are absorbed and keep the door open for a full dwell.
        clr = cur_hot;
        if ((call_req & cur_hot) != '0)
          cnt_d = DWELL_RELOAD;
        else if (cnt_q == '0)
          state_d = (pending_q != '0) ? SELECT : IDLE;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q | call_req) & ~clr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      target_q  <= '0;
      dir_up_q  <= 1'b1;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign target_floor = target_q;
  assign door_open    = (state_q == DOOR);
  assign busy         = (state_q != IDLE);
  assign dir_up       = dir_up_q;
  assign pending      = pending_q;

endmodule
